// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole cycle,
// with a hung-slave watchdog that aborts the cycle with err after TIMEOUT stalled cycles.
module wishbone_arbiter_2m #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_data_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_data_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_addr_o,
   output logic        s_we_o,
   output logic [31:0] s_data_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            r_state, w_state_nxt;
   logic              r_owner, w_owner_nxt;
   logic              r_last, w_last_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [1:0]        r_gnt, w_gnt_nxt;
   logic              w_req0, w_req1, w_own_cyc;

   assign w_req0    = m0_cyc_i & m0_stb_i;
   assign w_req1    = m1_cyc_i & m1_stb_i;
   assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_cnt   <= '0;
         r_gnt   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_req0 && w_req1) begin
               w_owner_nxt = ~r_last;
               w_state_nxt = ST_BUSY;
            end else if (w_req0 || w_req1) begin
               w_owner_nxt = w_req1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Release by the owner wins over a watchdog expiry on the same edge.
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_owner;
            end else if (s_ack_i) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = ST_ERR;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_ERR: begin
            if (!w_own_cyc) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_owner;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_gnt_nxt = (w_state_nxt == ST_IDLE) ? 2'b00 : (w_owner_nxt ? 2'b10 : 2'b01);
   end

   always_comb begin
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_data_o  = '0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m0_data_o = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_data_o = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      if (r_state == ST_BUSY) begin
         s_addr_o = r_owner ? m1_addr_i : m0_addr_i;
         s_we_o   = r_owner ? m1_we_i   : m0_we_i;
         s_data_o = r_owner ? m1_data_i : m0_data_i;
         s_cyc_o  = w_own_cyc;
         s_stb_o  = r_owner ? m1_stb_i  : m0_stb_i;
         if (r_owner) begin
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
         end else begin
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
         end
      end else if (r_state == ST_ERR) begin
         m0_err_o = ~r_owner;
         m1_err_o = r_owner;
      end
   end

   assign gnt_o     = r_gnt;
   assign timeout_o = (r_state == ST_ERR);

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Bench for wishbone_arbiter_2m: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_wishbone_arbiter_2m;

   localparam int TMO = 4;

   logic        clk, rst;
   logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;
   logic [31:0] m0_rdat, m1_rdat, s_addr, s_wdat;
   logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_cyc, s_stb, tmo;
   logic [1:0]  gnt;

   int n_checks = 0;
   int n_errors = 0;

   wishbone_arbiter_2m #(.TIMEOUT(TMO), .CNT_W(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_data_i(m0_wdat),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
      .m0_data_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_data_i(m1_wdat),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
      .m1_data_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .s_addr_o(s_addr), .s_we_o(s_we), .s_data_o(s_wdat),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb),
      .s_data_i(s_rdat), .s_ack_i(s_ack),
      .gnt_o(gnt), .timeout_o(tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level model: who holds the bus (-1 = nobody), whether the
   // held cycle was aborted, and how many consecutive stalled cycles so far.
   int m_owner = -1;
   bit m_aborted = 0;
   int m_stall = 0;
   int m_last = 1;
   bit model_ok = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_aborted = 0; m_stall = 0; m_last = 1; model_ok = 1;
      end else if (m_owner < 0) begin
         bit r0, r1;
         r0 = m0_cyc && m0_stb;
         r1 = m1_cyc && m1_stb;
         m_stall = 0;
         if (r0 && r1) m_owner = 1 - m_last;
         else if (r0) m_owner = 0;
         else if (r1) m_owner = 1;
      end else begin
         bit still;
         still = (m_owner == 0) ? m0_cyc : m1_cyc;
         if (!still) begin
            m_last = m_owner; m_owner = -1; m_aborted = 0;
         end else if (!m_aborted) begin
            if (s_ack) m_stall = 0;
            else begin
               m_stall++;
               if (m_stall == TMO) m_aborted = 1;
            end
         end
      end
   end

   logic [137:0] ev, av;
   always @(negedge clk) begin
      if (model_ok) begin
         bit b, e, o;
         b = (m_owner >= 0) && !m_aborted;
         e = (m_owner >= 0) && m_aborted;
         o = (m_owner == 1);
         ev = '0;
         if (b) begin
            ev[137:106] = o ? m1_addr : m0_addr;
            ev[105]     = o ? m1_we : m0_we;
            ev[104:73]  = o ? m1_wdat : m0_wdat;
            ev[72]      = o ? m1_cyc : m0_cyc;
            ev[71]      = o ? m1_stb : m0_stb;
            if (o) begin ev[36:5] = s_rdat; ev[4] = s_ack; end
            else   begin ev[70:39] = s_rdat; ev[38] = s_ack; end
         end
         ev[37] = e && !o;
         ev[3]  = e && o;
         ev[2:1] = (m_owner < 0) ? 2'b00 : (o ? 2'b10 : 2'b01);
         ev[0]  = e;
         av = {s_addr, s_we, s_wdat, s_cyc, s_stb, m0_rdat, m0_ack, m0_err,
               m1_rdat, m1_ack, m1_err, gnt, tmo};
         n_checks++;
         if (av !== ev) begin
            n_errors++;
            $display("FAIL model t=%0t got %h expected %h", $time, av, ev);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; s_ack = 0; s_rdat = 0;
      m0_addr = 0; m0_wdat = 0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
      m1_addr = 0; m1_wdat = 0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
      tick(); tick();
      rst = 0;
      #1;
      chk("reset_gnt", gnt, 0);
      chk("reset_scyc", s_cyc, 0);
      chk("reset_tmo", tmo, 0);

      // single m0 write
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h10; m0_wdat = 32'hA5;
      #1;
      chk("a_no_comb_grant", s_cyc, 0);
      tick(); #1;
      chk("a_scyc", s_cyc, 1);
      chk("a_gnt", gnt, 2'b01);
      chk("a_sdata", s_wdat, 32'hA5);
      s_ack = 1; #1;
      chk("a_m0ack", m0_ack, 1);
      chk("a_m1ack", m1_ack, 0);
      tick(); m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
      tick(); #1;
      chk("a_idle_gnt", gnt, 0);

      // simultaneous requests after reset alternate with an idle cycle between
      rst = 1; tick(); rst = 0;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick(); #1; chk("b_gnt0", gnt, 2'b01);
      m0_cyc = 0; m0_stb = 0;
      tick(); #1; chk("b_gnt1", gnt, 2'b00);
      m0_cyc = 1; m0_stb = 1;
      tick(); #1; chk("b_gnt2", gnt, 2'b10);
      chk("b_m0ack_held", m0_ack, 0);
      m1_cyc = 0; m1_stb = 0;
      tick(); #1; chk("b_gnt3", gnt, 2'b00);
      tick(); #1; chk("b_gnt4", gnt, 2'b01);
      m0_cyc = 0; m0_stb = 0;
      tick();

      // m1 read with m0 arriving mid-cycle
      m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h20;
      tick(); #1;
      chk("c_gnt", gnt, 2'b10);
      s_rdat = 32'hDEADBEEF; s_ack = 1; m0_cyc = 1; m0_stb = 1; #1;
      chk("c_m1data", m1_rdat, 32'hDEADBEEF);
      chk("c_m1ack", m1_ack, 1);
      chk("c_m0ack", m0_ack, 0);
      chk("c_m0data", m0_rdat, 0);
      tick(); m1_cyc = 0; m1_stb = 0; s_ack = 0; #1;
      chk("c_m0ack2", m0_ack, 0);
      tick(); #1; chk("c_idle", gnt, 2'b00);
      tick(); #1; chk("c_m0gnt", gnt, 2'b01);
      m0_cyc = 0; m0_stb = 0;
      tick();

      // hung slave: abort after exactly TMO busy cycles
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int i = 0; i < TMO - 1; i++) tick();
      #1;
      chk("d_last_busy_scyc", s_cyc, 1);
      chk("d_last_busy_tmo", tmo, 0);
      tick(); #1;
      chk("d_err_scyc", s_cyc, 0);
      chk("d_err_m0err", m0_err, 1);
      chk("d_err_tmo", tmo, 1);
      chk("d_err_gnt", gnt, 2'b01);
      tick(); #1;
      chk("d_err_hold", m0_err, 1);
      m0_cyc = 0; m0_stb = 0;
      tick(); #1;
      chk("d_idle_tmo", tmo, 0);
      chk("d_idle_err", m0_err, 0);

      // reset during an m1 cycle, then both request
      m1_cyc = 1; m1_stb = 1;
      tick(); #1; chk("e_gnt_m1", gnt, 2'b10);
      rst = 1;
      tick(); rst = 0; #1;
      chk("e_rst_gnt", gnt, 0);
      chk("e_rst_scyc", s_cyc, 0);
      chk("e_rst_m1ack", m1_ack, 0);
      m0_cyc = 1; m0_stb = 1;
      tick(); #1; chk("e_first_m0", gnt, 2'b01);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick(); tick();

      // release on the same edge the watchdog would fire
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int i = 0; i < TMO - 1; i++) tick();
      m0_cyc = 0; m0_stb = 0;
      tick(); #1;
      chk("f_tmo", tmo, 0);
      chk("f_err", m0_err, 0);
      chk("f_gnt", gnt, 0);
      tick(); #1;
      chk("f_tmo2", tmo, 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0);
         else        m0_cyc = ($urandom_range(0, 2) == 0);
         if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0);
         else        m1_cyc = ($urandom_range(0, 2) == 0);
         m0_stb = m0_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
         m1_stb = m1_cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
         m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
         m0_addr = $urandom; m1_addr = $urandom;
         m0_wdat = $urandom; m1_wdat = $urandom;
         s_rdat = $urandom;
         s_ack = ($urandom_range(0, 2) == 0);
      end
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wishbone_arbiter_2m.md
# wishbone_arbiter_2m

Two-master Wishbone arbiter sharing one slave port, e.g. the CPU data bus and the debug module in front of the LED/peripheral slave. It grants round-robin on simultaneous requests and holds the grant for the whole cycle. It watches for a hung slave and terminates the cycle with an error after a programmable number of cycles without acknowledge.

## Interface
- TIMEOUT, 16: BUSY cycles without `s_ack_i` before the error abort; legal range ≥2.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT ≤ 2^CNT_W.
- clk_i  in  1  sole clock, all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- m0_addr_i / m1_addr_i  in  32  master address.
- m0_we_i / m1_we_i  in  1  write enable, 1 = write.
- m0_data_i / m1_data_i  in  32  master write data.
- m0_cyc_i / m1_cyc_i  in  1  master cycle.
- m0_stb_i / m1_stb_i  in  1  master strobe.
- m0_data_o / m1_data_o  out  32  read data to master.
- m0_ack_o / m1_ack_o  out  1  acknowledge to master.
- m0_err_o / m1_err_o  out  1  timeout error to master.
- s_addr_o, s_we_o, s_data_o, s_cyc_o, s_stb_o  out  32/1/32/1/1  slave-side master signals.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge; the slave holds it until cyc/stb drop.
- gnt_o  out  2  one-hot current owner; 00 in IDLE.
- timeout_o  out  1  high while in ERR.

## Operation
- Request: reqN = mN_cyc_i & mN_stb_i. stb without cyc is not a request.
- Registers:
  - state: IDLE, BUSY, ERR.
  - owner: 1 bit.
  - last: 1 bit, the owner of the last completed cycle; reset value 1, so m0 wins first.
  - cnt: CNT_W bits.
- IDLE:
  - all slave-side outputs 0; all master outputs 0.
  - Only one reqN → owner=N, go to BUSY.
  - Both → owner=~last, go to BUSY.
  - None → stay in IDLE.
  - cnt cleared.
- BUSY:
  - s_addr/we/data/cyc/stb_o driven combinationally from the owner.
  - Owner gets data_o=s_data_i and ack_o=s_ack_i. Non-owner gets data_o=0, ack_o=0, err_o=0.
  - Owner mN_cyc_i=0 → IDLE, last=owner. This has priority over timeout.
  - Otherwise, if s_ack_i=1 → cnt=0.
  - Otherwise, if cnt==TIMEOUT-1 → ERR.
  - Otherwise cnt+1.
- ERR:
  - s_cyc_o=s_stb_o=0, which releases the slave; other slave outputs 0.
  - Owner err_o=1, ack_o=0, data_o=0.
  - Stays in ERR until owner cyc_i=0, then IDLE with last=owner.
  - timeout_o=1.
- The non-owner's request is held off with ack=0; it is never dropped. It wins the next arbitration because last≠it.
- Owner changing we/addr mid-cycle is passed through unchanged; the arbiter does not check it.

## Timing
- Reset values: state IDLE, cnt 0, last 1, owner 0. All outputs 0 in the cycle after the reset edge.
- Reset asserted in BUSY/ERR: next edge forces IDLE; slave cyc drops the same cycle.
- Grant latency: request sampled at edge E → s_cyc_o=1 in the cycle after E. No combinational path from mN_cyc_i to s_cyc_o while in IDLE.
- Slave→master path (ack, data) is combinational in BUSY; zero added latency.
- Release: owner cyc low at edge E → IDLE after E.
- Minimum one IDLE cycle between consecutive grants. Back-to-back requesters alternate with one idle cycle between cycles.
- Timeout: ERR entered at the edge ending the TIMEOUT-th consecutive BUSY cycle with s_ack_i=0.
- Owner cyc drop and cnt==TIMEOUT-1 on the same edge → IDLE, no error.
- gnt_o follows owner in BUSY and ERR; it is registered state, glitch-free.

## Test plan
- Single m0 write 0x0000_00A5 to a stub slave acking 1 cycle after stb → s_cyc_o rises 1 cycle after request; m0_ack_o mirrors s_ack_i; gnt_o=01; m1_ack_o stays 0.
- m0 and m1 request at the same edge after reset, both held → grants m0, IDLE, m1, IDLE, m0; gnt_o sequence 01,00,10,00,01.
- m1 read while slave returns 0xDEAD_BEEF; m0 requests mid-cycle → m1_data_o=0xDEAD_BEEF with ack; m0_ack_o=0 until m1 drops cyc; then m0 is granted after 1 idle cycle.
- TIMEOUT=4, slave never acks, m0 holds cyc → after exactly 4 BUSY cycles s_cyc_o=0, m0_err_o=1, timeout_o=1. These hold until m0 drops cyc, then IDLE.
- rst_i pulsed for 1 cycle during a BUSY m1 cycle → next cycle all outputs 0 and gnt_o=00. With both then requesting, m0 is granted first.
- Owner drops cyc on the same edge that cnt reaches TIMEOUT-1 → returns to IDLE; err_o and timeout_o never assert.
